// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the RV32 pipeline hazard/control unit.
package pipe_ctrl_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } pipe_state_e;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping; clear beats increment.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] q_r;

    // Count register: reset, clear, saturating increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            q_r <= {CNT_W{1'b0}};
        end else if (inc && (q_r != CNT_MAX)) begin
            q_r <= q_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/control unit for the 5-stage RV32 pipeline: forwarding, load-use stall,
// branch flush, dmem wait freeze with timeout, and saturating perf counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW      = 5,
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic [REG_AW-1:0] rs1_e,
    input  logic [REG_AW-1:0] rs2_e,
    input  logic [REG_AW-1:0] rd_e,
    input  logic              load_e,
    input  logic              pc_src_e,
    input  logic [REG_AW-1:0] rd_m,
    input  logic              reg_write_m,
    input  logic              mem_access_m,
    input  logic              dmem_ready,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              reg_write_w,
    input  logic              cnt_clr,
    output logic [1:0]        forward_a_e,
    output logic [1:0]        forward_b_e,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_e,
    output logic              stall_m,
    output logic              flush_d,
    output logic              flush_e,
    output logic              flush_w,
    output logic              mem_timeout,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [CNT_W-1:0]  lu_cnt
);

    localparam int TO_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [REG_AW-1:0] REG_X0   = {REG_AW{1'b0}};
    localparam logic [TO_W-1:0]   TO_LIMIT = TO_W'(MEM_TIMEOUT);

    pipe_state_e     state_r, state_nxt_s;
    logic [TO_W-1:0] wait_cnt_r, wait_cnt_nxt_s;
    logic            mem_timeout_r, timeout_set_s;

    logic       lu_s, to_hit_s, mem_stall_s;
    logic [1:0] fwd_a_s, fwd_b_s;
    logic       stall_f_s, stall_d_s, stall_e_s, stall_m_s;
    logic       flush_d_s, flush_e_s, flush_w_s;
    logic       flush_inc_s, lu_inc_s;

    // wait_cnt_r holds the number of cycles already stalled on the current access,
    // so the release lands after exactly MEM_TIMEOUT frozen cycles.
    assign to_hit_s    = (state_r == WAIT) && (wait_cnt_r == TO_LIMIT);
    assign mem_stall_s = mem_access_m && !dmem_ready && !to_hit_s;
    assign lu_s        = load_e && (rd_e != REG_X0) && ((rd_e == rs1_d) || (rd_e == rs2_d));

    // Operand forwarding selects, M stage preferred over W.
    always_comb begin
        fwd_a_s = FWD_RF;
        fwd_b_s = FWD_RF;
        if (rst) begin
            fwd_a_s = FWD_RF;
            fwd_b_s = FWD_RF;
        end else begin
            if (reg_write_m && (rd_m != REG_X0) && (rd_m == rs1_e)) begin
                fwd_a_s = FWD_MEM;
            end else if (reg_write_w && (rd_w != REG_X0) && (rd_w == rs1_e)) begin
                fwd_a_s = FWD_WB;
            end else begin
                fwd_a_s = FWD_RF;
            end
            if (reg_write_m && (rd_m != REG_X0) && (rd_m == rs2_e)) begin
                fwd_b_s = FWD_MEM;
            end else if (reg_write_w && (rd_w != REG_X0) && (rd_w == rs2_e)) begin
                fwd_b_s = FWD_WB;
            end else begin
                fwd_b_s = FWD_RF;
            end
        end
    end

    // Stall/flush priority: memory freeze, then redirect, then load-use.
    always_comb begin
        stall_f_s   = 1'b0;
        stall_d_s   = 1'b0;
        stall_e_s   = 1'b0;
        stall_m_s   = 1'b0;
        flush_d_s   = 1'b0;
        flush_e_s   = 1'b0;
        flush_w_s   = 1'b0;
        flush_inc_s = 1'b0;
        lu_inc_s    = 1'b0;
        if (rst) begin
            stall_f_s = 1'b0;
        end else if (mem_stall_s) begin
            stall_f_s = 1'b1;
            stall_d_s = 1'b1;
            stall_e_s = 1'b1;
            stall_m_s = 1'b1;
            flush_w_s = 1'b1;
        end else if (pc_src_e) begin
            flush_d_s   = 1'b1;
            flush_e_s   = 1'b1;
            flush_inc_s = 1'b1;
        end else if (lu_s) begin
            stall_f_s = 1'b1;
            stall_d_s = 1'b1;
            flush_e_s = 1'b1;
            lu_inc_s  = 1'b1;
        end else begin
            stall_f_s = 1'b0;
        end
    end

    // Memory-wait FSM next state; leaving WAIT through the limit raises the sticky flag.
    always_comb begin
        state_nxt_s    = state_r;
        wait_cnt_nxt_s = wait_cnt_r;
        timeout_set_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (mem_stall_s) begin
                    state_nxt_s    = WAIT;
                    wait_cnt_nxt_s = {{(TO_W-1){1'b0}}, 1'b1};
                end else begin
                    state_nxt_s    = IDLE;
                    wait_cnt_nxt_s = {TO_W{1'b0}};
                end
            end
            WAIT: begin
                if (mem_stall_s) begin
                    state_nxt_s    = WAIT;
                    wait_cnt_nxt_s = wait_cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
                end else begin
                    state_nxt_s    = IDLE;
                    wait_cnt_nxt_s = {TO_W{1'b0}};
                    timeout_set_s  = to_hit_s;
                end
            end
            default: begin
                state_nxt_s    = IDLE;
                wait_cnt_nxt_s = {TO_W{1'b0}};
            end
        endcase
    end

    // FSM, wait counter and sticky timeout registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            wait_cnt_r    <= {TO_W{1'b0}};
            mem_timeout_r <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            wait_cnt_r    <= wait_cnt_nxt_s;
            mem_timeout_r <= mem_timeout_r | timeout_set_s;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk (clk), .rst (rst), .clr (cnt_clr), .inc (stall_f_s), .q (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk (clk), .rst (rst), .clr (cnt_clr), .inc (flush_inc_s), .q (flush_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_lu_cnt (
        .clk (clk), .rst (rst), .clr (cnt_clr), .inc (lu_inc_s), .q (lu_cnt)
    );

    assign forward_a_e = fwd_a_s;
    assign forward_b_e = fwd_b_s;
    assign stall_f     = stall_f_s;
    assign stall_d     = stall_d_s;
    assign stall_e     = stall_e_s;
    assign stall_m     = stall_m_s;
    assign flush_d     = flush_d_s;
    assign flush_e     = flush_e_s;
    assign flush_w     = flush_w_s;
    assign mem_timeout = mem_timeout_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a small counter width and short timeout.
module tb_pipe_hazard_ctrl;

    localparam int REG_AW = 5;
    localparam int CNT_W  = 3;
    localparam int MEM_TO = 4;

    // {0, stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w}
    localparam logic [7:0] C_NONE = 8'b0000_0000;
    localparam logic [7:0] C_MEM  = 8'b0111_1001;
    localparam logic [7:0] C_LU   = 8'b0110_0010;
    localparam logic [7:0] C_REDIR = 8'b0000_0110;

    logic clk = 1'b0;
    logic rst;
    logic [REG_AW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic load_e, pc_src_e, reg_write_m, mem_access_m, dmem_ready, reg_write_w, cnt_clr;
    logic [1:0] forward_a_e, forward_b_e;
    logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, mem_timeout;
    logic [CNT_W-1:0] stall_cnt, flush_cnt, lu_cnt;

    int vectors = 0;
    int miscompares = 0;

    wire [7:0] ctrl_w  = {1'b0, stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w};
    wire [7:0] fwda_w  = {6'b0, forward_a_e};
    wire [7:0] fwdb_w  = {6'b0, forward_b_e};
    wire [7:0] scnt_w  = {5'b0, stall_cnt};
    wire [7:0] fcnt_w  = {5'b0, flush_cnt};
    wire [7:0] lcnt_w  = {5'b0, lu_cnt};
    wire [7:0] mto_w   = {7'b0, mem_timeout};

    pipe_hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TO)) dut (
        .clk(clk), .rst(rst),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
        .load_e(load_e), .pc_src_e(pc_src_e), .rd_m(rd_m), .reg_write_m(reg_write_m),
        .mem_access_m(mem_access_m), .dmem_ready(dmem_ready), .rd_w(rd_w),
        .reg_write_w(reg_write_w), .cnt_clr(cnt_clr),
        .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
        .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
        .mem_timeout(mem_timeout),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .lu_cnt(lu_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rs1_d = 5'd0; rs2_d = 5'd0; rs1_e = 5'd0; rs2_e = 5'd0;
        rd_e = 5'd0; rd_m = 5'd0; rd_w = 5'd0;
        load_e = 1'b0; pc_src_e = 1'b0; reg_write_m = 1'b0; reg_write_w = 1'b0;
        mem_access_m = 1'b0; dmem_ready = 1'b0; cnt_clr = 1'b0;
    endtask

    initial begin
        // Reset with hazards present on the inputs: outputs must stay quiet.
        rst = 1'b1;
        idle_inputs();
        reg_write_m = 1'b1; rd_m = 5'd5; rs1_e = 5'd5;
        load_e = 1'b1; rd_e = 5'd7; rs1_d = 5'd7; mem_access_m = 1'b1;
        #1;
        chk("rst_fwd_a", fwda_w, 8'd0);
        chk("rst_ctrl", ctrl_w, C_NONE);
        tick();
        tick();
        rst = 1'b0;
        idle_inputs();
        #1;
        chk("post_rst_ctrl", ctrl_w, C_NONE);
        chk("post_rst_stall_cnt", scnt_w, 8'd0);
        chk("post_rst_flush_cnt", fcnt_w, 8'd0);
        chk("post_rst_lu_cnt", lcnt_w, 8'd0);
        chk("post_rst_timeout", mto_w, 8'd0);

        // Forwarding
        reg_write_m = 1'b1; reg_write_w = 1'b1; rd_m = 5'd5; rd_w = 5'd5;
        rs1_e = 5'd5; rs2_e = 5'd5;
        #1;
        chk("fwd_a_mem", fwda_w, 8'd2);
        chk("fwd_b_mem", fwdb_w, 8'd2);
        reg_write_m = 1'b0;
        #1;
        chk("fwd_a_wb", fwda_w, 8'd1);
        chk("fwd_b_wb", fwdb_w, 8'd1);
        reg_write_m = 1'b1; rd_m = 5'd0; rd_w = 5'd0; rs1_e = 5'd0; rs2_e = 5'd0;
        #1;
        chk("fwd_a_x0", fwda_w, 8'd0);
        chk("fwd_b_x0", fwdb_w, 8'd0);
        rd_m = 5'd5; rd_w = 5'd3; rs1_e = 5'd5; rs2_e = 5'd3;
        #1;
        chk("fwd_a_mix", fwda_w, 8'd2);
        chk("fwd_b_mix", fwdb_w, 8'd1);
        idle_inputs();

        // Load-use stall, then load-use coincident with redirect
        load_e = 1'b1; rd_e = 5'd7; rs2_d = 5'd7;
        #1;
        chk("lu_ctrl", ctrl_w, C_LU);
        tick();
        idle_inputs();
        #1;
        chk("lu_released", ctrl_w, C_NONE);
        chk("lu_lu_cnt", lcnt_w, 8'd1);
        chk("lu_stall_cnt", scnt_w, 8'd1);
        load_e = 1'b1; rd_e = 5'd7; rs2_d = 5'd7; pc_src_e = 1'b1;
        #1;
        chk("redir_ctrl", ctrl_w, C_REDIR);
        tick();
        idle_inputs();
        #1;
        chk("redir_flush_cnt", fcnt_w, 8'd1);
        chk("redir_lu_cnt", lcnt_w, 8'd1);
        chk("redir_stall_cnt", scnt_w, 8'd1);
        load_e = 1'b1; rd_e = 5'd0; rs1_d = 5'd0;
        #1;
        chk("lu_x0", ctrl_w, C_NONE);
        idle_inputs();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        #1;
        chk("clr_stall_cnt", scnt_w, 8'd0);
        chk("clr_flush_cnt", fcnt_w, 8'd0);

        // Three-cycle memory wait with a redirect arriving mid-wait
        mem_access_m = 1'b1; dmem_ready = 1'b0;
        #1;
        chk("mw_c1", ctrl_w, C_MEM);
        tick();
        pc_src_e = 1'b1;
        #1;
        chk("mw_c2_redir", ctrl_w, C_MEM);
        tick();
        pc_src_e = 1'b0;
        #1;
        chk("mw_c3", ctrl_w, C_MEM);
        tick();
        dmem_ready = 1'b1;
        #1;
        chk("mw_ready", ctrl_w, C_NONE);
        tick();
        idle_inputs();
        #1;
        chk("mw_stall_cnt", scnt_w, 8'd3);
        chk("mw_flush_cnt", fcnt_w, 8'd0);
        chk("mw_timeout", mto_w, 8'd0);

        // Zero-wait access
        mem_access_m = 1'b1; dmem_ready = 1'b1;
        #1;
        chk("zw_ctrl", ctrl_w, C_NONE);
        tick();
        idle_inputs();
        #1;
        chk("zw_stall_cnt", scnt_w, 8'd3);

        // Timeout: dmem_ready never rises
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        mem_access_m = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < MEM_TO; i++) begin
            #1;
            chk($sformatf("to_stall_%0d", i), ctrl_w, C_MEM);
            tick();
        end
        #1;
        chk("to_release", ctrl_w, C_NONE);
        chk("to_flag_before", mto_w, 8'd0);
        tick();
        idle_inputs();
        #1;
        chk("to_flag", mto_w, 8'd1);
        chk("to_stall_cnt", scnt_w, 8'd4);
        tick();
        tick();
        chk("to_flag_held", mto_w, 8'd1);

        // Saturation and clear-over-increment
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        load_e = 1'b1; rd_e = 5'd7; rs1_d = 5'd7;
        repeat (9) tick();
        chk("sat_stall_cnt", scnt_w, 8'd7);
        chk("sat_lu_cnt", lcnt_w, 8'd7);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("clr_wins_stall", scnt_w, 8'd0);
        chk("clr_wins_lu", lcnt_w, 8'd0);
        tick();
        chk("count_after_clr", scnt_w, 8'd1);
        idle_inputs();
        #1;
        chk("to_flag_survives_clr", mto_w, 8'd1);

        // Reset in the middle of a wait
        mem_access_m = 1'b1; dmem_ready = 1'b0;
        tick();
        tick();
        chk("rw_waiting", ctrl_w, C_MEM);
        rst = 1'b1;
        reg_write_m = 1'b1; rd_m = 5'd5; rs1_e = 5'd5;
        #1;
        chk("rw_ctrl_in_rst", ctrl_w, C_NONE);
        chk("rw_fwd_in_rst", fwda_w, 8'd0);
        tick();
        rst = 1'b0;
        idle_inputs();
        mem_access_m = 1'b1;
        #1;
        chk("rw_stall_cnt", scnt_w, 8'd0);
        chk("rw_timeout", mto_w, 8'd0);
        // Fresh wait from IDLE must again last the full timeout.
        for (int i = 0; i < MEM_TO; i++) begin
            #1;
            chk($sformatf("rw_stall_%0d", i), ctrl_w, C_MEM);
            tick();
        end
        #1;
        chk("rw_release", ctrl_w, C_NONE);
        tick();
        idle_inputs();
        #1;
        chk("rw_to_flag", mto_w, 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
